// File: rtl/mult_div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
//   Shared types and constants for the multicycle HI/LO unit
//   (mult_div_sequencer and its md_datapath).
//   Contents:
//     MD_WIDTH_DEFAULT  default operand width (32)
//     md_state_t        sequencer states IDLE, MULT_RUN, DIV_RUN, FIX, DONE
//     md_op_t           operation selector OP_MULT / OP_DIV
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    FIX,
    DONE
  } md_state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } md_op_t;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer_if
//   Request/response bundle between the main control unit (master) and the
//   HI/LO unit (slave).
//   Signals:
//     mult_start, div_start  1-cycle start requests from the control unit
//     op_a, op_b             rs / rt operands, sampled on the accepted start
//     abort                  exception flush (present only with MD_ABORT_EN)
//     busy, done, div_zero   registered status from the HI/LO unit
//     hi_out, lo_out         HI and LO registers
//   Build option: define MD_ABORT_EN to add the abort signal.
// -----------------------------------------------------------------------------
interface mult_div_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

`ifdef MD_ABORT_EN
  logic             abort;

  modport master (
    output mult_start, div_start, op_a, op_b, abort,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b, abort,
    output busy, done, div_zero, hi_out, lo_out
  );
`else
  modport master (
    output mult_start, div_start, op_a, op_b,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output busy, done, div_zero, hi_out, lo_out
  );
`endif

endinterface

// File: rtl/mult_div_sequencer_datapath.sv
// -----------------------------------------------------------------------------
// md_datapath
//   Unsigned magnitude engine for the HI/LO unit. Holds the second operand
//   magnitude and a 2*WIDTH shift accumulator, and shares one WIDTH+1 bit
//   adder between shift-add multiply and restoring divide.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     load         capture a_mag into acc[WIDTH-1:0] (upper half cleared)
//                  and b_mag into the operand register
//     step         perform one iteration of op
//     op           OP_MULT or OP_DIV, stable while stepping
//     a_mag        multiplier / dividend magnitude
//     b_mag        multiplicand / divisor magnitude
//     acc          after WIDTH steps: product (MULT) or {remainder, quotient} (DIV)
// -----------------------------------------------------------------------------
module md_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  md_op_t             op,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     add_cin;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

  // MULT: upper half plus (b if the current multiplier bit is set); the
  //   carry lands in bit WIDTH and is shifted back in below.
  // DIV: partial remainder shifted left by one (taking the next dividend bit)
  //   minus b, done as x + ~b + 1. sum[WIDTH] set means the trial went negative.
  assign add_x   = (op == OP_MULT) ? {1'b0, acc[2*WIDTH-1:WIDTH]} : acc[2*WIDTH-1:WIDTH-1];
  assign add_y   = (op == OP_MULT) ? (acc[0] ? {1'b0, b_q} : '0) : ~{1'b0, b_q};
  assign add_cin = {{WIDTH{1'b0}}, (op == OP_DIV)};
  assign sum     = add_x + add_y + add_cin;

  always_comb begin
    // NOTE: give every always_comb target a default first; a branch that
    // skips an assignment would otherwise infer a latch.
    acc_next = acc;
    if (op == OP_MULT) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (!sum[WIDTH]) begin
      acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      acc <= '0;
      b_q <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, a_mag};
      b_q <= b_mag;
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer
//   Multicycle HI/LO unit for the MIPS core. Runs signed MULT and DIV one bit
//   per cycle on operand magnitudes, applies signs in FIX and writes HI/LO.
//   Owns the HI/LO registers read directly by MFHI/MFLO.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; also cancels an operation in flight
//     bus    mult_div_sequencer_if.slave:
//              mult_start/div_start, op_a/op_b in;
//              busy/done/div_zero, hi_out/lo_out out (all registered)
//   Build option: MD_ABORT_EN adds bus.abort, which returns an operation in
//   MULT_RUN/DIV_RUN/FIX to IDLE without done and without touching HI/LO.
//   Latency: start accepted at edge E0 -> busy for WIDTH+1 cycles -> done in
//   cycle E0+WIDTH+2. Divide by zero -> done with div_zero in cycle E0+1.
// -----------------------------------------------------------------------------
module mult_div_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  mult_div_sequencer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state;
  md_op_t             op_q;
  logic [CW-1:0]      count;
  logic               neg_a;
  logic               neg_b;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               abort_req;
  logic               accept_mult;
  logic               accept_div;
  logic               div_by_zero;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

`ifdef MD_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // MULT wins a simultaneous request; abort suppresses any start in IDLE.
  assign accept_mult = (state == IDLE) && !abort_req && bus.mult_start;
  assign accept_div  = (state == IDLE) && !abort_req && !bus.mult_start && bus.div_start;
  assign div_by_zero = (bus.op_b == '0);
  assign load        = accept_mult || (accept_div && !div_by_zero);
  assign step        = ((state == MULT_RUN) || (state == DIV_RUN)) && !abort_req;

  // The most negative value maps to itself, which is its correct unsigned magnitude.
  assign a_mag = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
  assign b_mag = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;

  md_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .op    (op_q),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .acc   (acc)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  // 0x80000000 / -1 yields quotient magnitude 0x80000000 with positive sign,
  // which is left as 0x80000000.
  assign product   = (neg_a ^ neg_b) ? -acc : acc;
  assign quotient  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remainder = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_MULT;
      count      <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state  <= accept_mult ? MULT_RUN : DIV_RUN;
            op_q   <= accept_mult ? OP_MULT : OP_DIV;
            count  <= CW'(WIDTH - 1);
            neg_a  <= bus.op_a[WIDTH-1];
            neg_b  <= bus.op_b[WIDTH-1];
            busy_q <= 1'b1;
          end else if (accept_div) begin
            state      <= DONE;
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (abort_req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        FIX: begin
          if (abort_req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (op_q == OP_MULT) begin
              hi_q <= product[2*WIDTH-1:WIDTH];
              lo_q <= product[WIDTH-1:0];
            end else begin
              hi_q <= remainder;
              lo_q <= quotient;
            end
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule
